load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/load_unit_pkg.sv | 34 +++
 rtl/load_unit_align_ext.sv | 29 ++
 rtl/load_unit.sv | 164 ++++++++++++++++
 tb/tb_load_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared definitions for the load unit: size encodings, FSM states,
// default timeout and the alignment rule.
package load_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  localparam int TIMEOUT_CYCLES_DEF = 15;

  // An access is misaligned when its offset does not fit its natural size;
  // the reserved size code is always treated as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic res;
    case (size)
      SIZE_BYTE: res = 1'b0;
      SIZE_HALF: res = off[0];
      SIZE_WORD: res = (off != 2'b00);
      default:   res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_unit_align_ext.sv
// Little-endian lane select and sign/zero extension of a read word.
module load_align_ext
  import load_unit_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [DataWidth-1:0] word,
  input  logic [1:0]           offset,
  input  logic [1:0]           size,
  input  logic                 uns,
  output logic [DataWidth-1:0] ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane and extend it to the full data width.
  always_comb begin
    byte_s = word[{offset, 3'b000} +: 8];
    half_s = word[{offset[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: ext = {{(DataWidth-8){byte_s[7] & ~uns}}, byte_s};
      SIZE_HALF: ext = {{(DataWidth-16){half_s[15] & ~uns}}, half_s};
      SIZE_WORD: ext = word;
      default:   ext = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: aligns/extends a memory word into LoadData,
// flags misaligned requests and memory timeouts.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 32,
  parameter int TimeoutCycles = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [1:0]           Size,
  input  logic                 Unsigned,
  output logic                 MemReq,
  output logic [AddrWidth-1:0] MemAddr,
  input  logic                 MemAck,
  input  logic [DataWidth-1:0] MemRData,
  output logic [DataWidth-1:0] LoadData,
  output logic                 Done,
  output logic                 Busy,
  output logic                 Misalign,
  output logic                 Timeout
);

  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  state_e                 state_r, state_s;
  logic [CntW-1:0]        cnt_r;
  logic [1:0]             size_r;
  logic [1:0]             off_r;
  logic                   uns_r;
  logic [AddrWidth-1:0]   memaddr_r;
  logic [DataWidth-1:0]   loaddata_r;
  logic                   memreq_r, done_r, busy_r, misalign_r, timeout_r;
  logic                   misalign_s, timeout_s, accept_s, capture_s;
  logic [DataWidth-1:0]   ext_s;

  load_align_ext #(.DataWidth(DataWidth)) u_align (
    .word   (MemRData),
    .offset (off_r),
    .size   (size_r),
    .uns    (uns_r),
    .ext    (ext_s)
  );

  assign accept_s  = (state_r == ST_IDLE) && Start;
  assign capture_s = (state_r == ST_REQ) && MemAck;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and the error flags that accompany entry to ERR.
  always_comb begin
    state_s    = state_r;
    misalign_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          if (is_misaligned(Size, Addr[1:0])) begin
            state_s    = ST_ERR;
            misalign_s = 1'b1;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (MemAck) begin
          state_s = ST_DONE;
        end else if (cnt_r == CntLast) begin
          state_s   = ST_ERR;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      ST_ERR:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Wait counter: zero outside REQ, counts REQ cycles that see no ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (state_r != ST_REQ) begin
      cnt_r <= '0;
    end else if (!MemAck) begin
      cnt_r <= cnt_r + CntW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Latch request attributes when a Start is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memaddr_r <= '0;
      size_r    <= 2'b00;
      off_r     <= 2'b00;
      uns_r     <= 1'b0;
    end else if (accept_s) begin
      memaddr_r <= {Addr[AddrWidth-1:2], 2'b00};
      size_r    <= Size;
      off_r     <= Addr[1:0];
      uns_r     <= Unsigned;
    end else begin
      memaddr_r <= memaddr_r;
      size_r    <= size_r;
      off_r     <= off_r;
      uns_r     <= uns_r;
    end
  end

  // Result register: only a successful ack may update it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaddata_r <= '0;
    end else if (capture_s) begin
      loaddata_r <= ext_s;
    end else begin
      loaddata_r <= loaddata_r;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memreq_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      misalign_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      memreq_r   <= (state_s == ST_REQ);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE) || (state_s == ST_ERR);
      misalign_r <= misalign_s;
      timeout_r  <= timeout_s;
    end
  end

  assign MemReq   = memreq_r;
  assign MemAddr  = memaddr_r;
  assign LoadData = loaddata_r;
  assign Done     = done_r;
  assign Busy     = busy_r;
  assign Misalign = misalign_r;
  assign Timeout  = timeout_r;

endmodule

// File: tb/tb_load_unit.sv
// Directed and randomized bench for load_unit with a behavioural load model.
module tb_load_unit;

  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic        Start;
  logic [31:0] Addr;
  logic [1:0]  Size;
  logic        Unsigned;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemRData;
  logic [31:0] LoadData;
  logic        Done;
  logic        Busy;
  logic        Misalign;
  logic        Timeout;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ld;

  load_unit #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .Start    (Start),
    .Addr     (Addr),
    .Size     (Size),
    .Unsigned (Unsigned),
    .MemReq   (MemReq),
    .MemAddr  (MemAddr),
    .MemAck   (MemAck),
    .MemRData (MemRData),
    .LoadData (LoadData),
    .Done     (Done),
    .Busy     (Busy),
    .Misalign (Misalign),
    .Timeout  (Timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misal(input logic [31:0] a, input int sz);
    if (sz == 3) return 1'b1;
    if (sz == 1) return (a % 2) != 0;
    if (sz == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input int sz, input bit u,
                                        input logic [31:0] d);
    longint unsigned v;
    if (sz == 0) begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (!u && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!u && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = d;
    end
    return v[31:0];
  endfunction

  // One complete load; dly >= TO means the memory never acks.
  task automatic do_load(input logic [31:0] a, input int sz, input bit u, input logic [31:0] d,
                         input int dly, input bit noise);
    int  nreq;
    bit  acked;
    @(negedge clk);
    Start = 1'b1; Addr = a; Size = sz[1:0]; Unsigned = u;
    @(negedge clk);
    Start = 1'b0; Addr = $urandom; Size = 2'($urandom); Unsigned = 1'($urandom);
    if (misal(a, sz)) begin
      check("err_memreq", MemReq, 1'b0);
      check("err_done", Done, 1'b1);
      check("err_busy", Busy, 1'b1);
      check("err_misalign", Misalign, 1'b1);
      check("err_timeout", Timeout, 1'b0);
      check("err_hold", LoadData, exp_ld);
    end else begin
      nreq  = 0;
      acked = 1'b0;
      for (int k = 0; k < TO && !acked; k++) begin
        check("req_memreq", MemReq, 1'b1);
        check("req_addr", MemAddr, a & 32'hFFFF_FFFC);
        check("req_done", Done, 1'b0);
        nreq += int'(MemReq);
        if (noise) Start = 1'($urandom);
        if (k == dly) begin
          MemAck = 1'b1; MemRData = d; acked = 1'b1;
        end else begin
          MemRData = $urandom;
        end
        @(negedge clk);
        MemAck = 1'b0; Start = 1'b0;
      end
      if (acked) begin
        exp_ld = model(a, sz, u, d);
        check("ok_done", Done, 1'b1);
        check("ok_flags", {Misalign, Timeout}, 2'b00);
        check("ok_memreq", MemReq, 1'b0);
        check("ok_data", LoadData, exp_ld);
      end else begin
        check("to_reqcycles", nreq, TO);
        check("to_done", Done, 1'b1);
        check("to_timeout", Timeout, 1'b1);
        check("to_misalign", Misalign, 1'b0);
        check("to_memreq", MemReq, 1'b0);
        check("to_hold", LoadData, exp_ld);
      end
    end
    // Done cycle: a Start or stray ack here must be ignored.
    if (noise) begin
      Start = 1'b1; MemAck = 1'b1; MemRData = ~exp_ld;
    end
    @(negedge clk);
    Start = 1'b0; MemAck = 1'b0;
    check("idle_busy", Busy, 1'b0);
    check("idle_done", Done, 1'b0);
    check("idle_memreq", MemReq, 1'b0);
    if (noise) begin
      MemAck = 1'b1; MemRData = ~exp_ld;
      @(negedge clk);
      MemAck = 1'b0;
      check("stray_done", Done, 1'b0);
      check("stray_busy", Busy, 1'b0);
      check("stray_data", LoadData, exp_ld);
    end
  endtask

  initial begin
    rst = 1'b0; Start = 1'b0; Addr = 32'h0; Size = 2'b00; Unsigned = 1'b0;
    MemAck = 1'b0; MemRData = 32'h0; exp_ld = 32'h0;
    #12;
    check("rst_outs", {MemReq, Done, Busy, Misalign, Timeout}, 5'b00000);
    check("rst_data", LoadData, 32'h0);
    check("rst_addr", MemAddr, 32'h0);
    @(negedge clk); rst = 1'b1;

    // Signed byte from lane 3, ack in first REQ cycle.
    do_load(32'h0000_0103, 0, 1'b0, 32'h80FF_1234, 0, 1'b0);
    check("d1_value", LoadData, 32'hFFFF_FF80);
    // Unsigned upper half.
    do_load(32'h0000_0102, 1, 1'b1, 32'h8001_0000, 2, 1'b0);
    check("d2_value", LoadData, 32'h0000_8001);
    // Misaligned word.
    do_load(32'h0000_0201, 2, 1'b0, 32'h1234_5678, 0, 1'b0);
    // Aligned word, never acked.
    do_load(32'h0000_0040, 2, 1'b0, 32'h1234_5678, 99, 1'b0);
    // Busy-time Start pulses and stray acks.
    do_load(32'h0000_0044, 2, 1'b1, 32'hCAFE_F00D, 4, 1'b1);
    // Ack in the last allowed REQ cycle.
    do_load(32'h0000_0081, 0, 1'b1, 32'h0000_AB00, TO - 1, 1'b0);
    // Reserved size.
    do_load(32'h0000_0000, 3, 1'b0, 32'h0, 0, 1'b1);

    // Reset in the middle of REQ.
    @(negedge clk);
    Start = 1'b1; Addr = 32'h0000_0300; Size = 2'b10; Unsigned = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    check("mid_memreq", MemReq, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_rst_outs", {MemReq, Done, Busy, Misalign, Timeout}, 5'b00000);
    check("mid_rst_data", LoadData, 32'h0);
    check("mid_rst_addr", MemAddr, 32'h0);
    exp_ld = 32'h0;
    @(negedge clk);
    MemAck = 1'b1;
    @(negedge clk);
    MemAck = 1'b0;
    check("mid_no_done", Done, 1'b0);
    rst = 1'b1;
    do_load(32'h0000_0306, 1, 1'b0, 32'h9ABC_0000, 1, 1'b0);
    check("post_rst_value", LoadData, 32'hFFFF_9ABC);

    // Randomized loads.
    for (int i = 0; i < 40; i++) begin
      do_load($urandom, $urandom_range(0, 3), 1'($urandom), $urandom,
              $urandom_range(0, TO + 1), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
